// File: rtl/onchip_mem_march_bist.sv
// Flop-based 2**ADDR_BITS x WIDTH memory with a host port, a stuck-at-1 fault injector
// and a March C- BIST engine that counts mismatches and captures the first failure.
module onchip_mem_march_bist #(
    parameter int ADDR_BITS = 4,
    parameter int WIDTH     = 8,
    parameter int ERR_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] host_addr,
    input  logic [WIDTH-1:0]     host_wdata,
    input  logic                 host_we,
    output logic [WIDTH-1:0]     host_rdata,
    input  logic                 start,
    input  logic [1:0]           bg_mode,
    input  logic                 inject_en,
    input  logic [ADDR_BITS-1:0] inject_addr,
    input  logic [WIDTH-1:0]     inject_mask,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_BITS-1:0]  err_count,
    output logic [ADDR_BITS-1:0] fail_addr,
    output logic [2:0]           fail_elem
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [WIDTH-1:0] CHK = WIDTH'({(WIDTH/2){2'b01}});

    typedef enum logic [2:0] {S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DONE} state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_BITS-1:0]  r_addr, w_addr_nxt;
    logic                  r_phase, w_phase_nxt;
    logic [1:0]            r_bg_mode;
    logic [ERR_BITS-1:0]   r_err;
    logic [ADDR_BITS-1:0]  r_fail_addr;
    logic [2:0]            r_fail_elem;
    logic [WIDTH-1:0]      r_mem [DEPTH];

    logic                  w_busy, w_start_acc, w_rd_op, w_wr_op, w_rd_inv, w_wr_inv;
    logic                  w_down, w_two_op, w_at_end, w_mis;
    logic [2:0]            w_elem;
    logic [WIDTH-1:0]      w_bg, w_bist_rd, w_wdata;

    function automatic logic [WIDTH-1:0] bg_val(input logic [1:0] mode,
                                                input logic [ADDR_BITS-1:0] a);
        logic [WIDTH-1:0] v;
        case (mode)
            2'b00:   v = '0;
            2'b01:   v = a[0] ? ~CHK : CHK;
            2'b10:   v = WIDTH'(a);
            default: v = '1;
        endcase
        return v;
    endfunction

    // Injection sits on the read path only, so host and BIST see the same faulty word.
    assign host_rdata = r_mem[host_addr] |
                        ((inject_en && host_addr == inject_addr) ? inject_mask : '0);
    assign w_bist_rd  = r_mem[r_addr] |
                        ((inject_en && r_addr == inject_addr) ? inject_mask : '0);

    assign w_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_start_acc = !w_busy && start;
    assign w_bg        = bg_val(r_bg_mode, r_addr);
    assign w_wdata     = w_bg ^ {WIDTH{w_wr_inv}};
    assign w_mis       = w_rd_op && (w_bist_rd != (w_bg ^ {WIDTH{w_rd_inv}}));

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_phase_nxt = r_phase;
        w_rd_op     = 1'b0;
        w_wr_op     = 1'b0;
        w_rd_inv    = 1'b0;
        w_wr_inv    = 1'b0;
        w_elem      = 3'd0;
        w_down      = (r_state == S_M3) || (r_state == S_M4);
        w_two_op    = (r_state == S_M1) || (r_state == S_M2) ||
                      (r_state == S_M3) || (r_state == S_M4);
        w_at_end    = w_down ? (r_addr == '0) : (r_addr == '1);
        case (r_state)
            S_M0: w_wr_op = 1'b1;
            S_M1: begin w_elem = 3'd1; w_wr_inv = 1'b1; end
            S_M2: begin w_elem = 3'd2; w_rd_inv = 1'b1; end
            S_M3: begin w_elem = 3'd3; w_wr_inv = 1'b1; end
            S_M4: begin w_elem = 3'd4; w_rd_inv = 1'b1; end
            S_M5: begin w_elem = 3'd5; w_rd_op = 1'b1; end
            default: ;
        endcase
        if (w_two_op) begin
            w_rd_op     = !r_phase;
            w_wr_op     = r_phase;
            w_phase_nxt = !r_phase;
        end

        if (w_start_acc) begin
            w_state_nxt = S_M0;
            w_addr_nxt  = '0;
            w_phase_nxt = 1'b0;
        end else if (w_busy && (!w_two_op || r_phase)) begin
            if (!w_at_end) begin
                w_addr_nxt = w_down ? r_addr - 1'b1 : r_addr + 1'b1;
            end else begin
                // Element boundary: next element starts at its own first address.
                case (r_state)
                    S_M0:    begin w_state_nxt = S_M1; w_addr_nxt = '0; end
                    S_M1:    begin w_state_nxt = S_M2; w_addr_nxt = '0; end
                    S_M2:    begin w_state_nxt = S_M3; w_addr_nxt = '1; end
                    S_M3:    begin w_state_nxt = S_M4; w_addr_nxt = '1; end
                    S_M4:    begin w_state_nxt = S_M5; w_addr_nxt = '0; end
                    default: begin w_state_nxt = S_DONE; w_addr_nxt = '0; end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_phase     <= 1'b0;
            r_bg_mode   <= 2'b00;
            r_err       <= '0;
            r_fail_addr <= '0;
            r_fail_elem <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_phase <= w_phase_nxt;
            if (w_start_acc) begin
                r_bg_mode   <= bg_mode;
                r_err       <= '0;
                r_fail_addr <= '0;
                r_fail_elem <= 3'd0;
            end else if (w_mis) begin
                if (r_err != '1) r_err <= r_err + ERR_BITS'(1);
                if (r_err == '0) begin
                    r_fail_addr <= r_addr;
                    r_fail_elem <= w_elem;
                end
            end
        end
    end

    // Host writes only while idle, so they never collide with march writes.
    always_ff @(posedge clk) begin
        if (w_wr_op)
            r_mem[r_addr] <= w_wdata;
        else if (!w_busy && host_we)
            r_mem[host_addr] <= host_wdata;
    end

    assign busy      = w_busy;
    assign done      = (r_state == S_DONE);
    assign pass      = (r_state == S_DONE) && (r_err == '0);
    assign err_count = r_err;
    assign fail_addr = r_fail_addr;
    assign fail_elem = r_fail_elem;

endmodule
